// File: rtl/regfile.sv
// 32x32 MIPS register file: two combinational read ports, one synchronous write port,
// same-cycle WB->ID bypass and a post-reset clear sequencer that stalls the pipeline.
module regfile #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned REG_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(REG_NUM)-1:0] waddr,
    input  logic [REG_W-1:0]           wdata,
    input  logic                       re1,
    input  logic [$clog2(REG_NUM)-1:0] raddr1,
    output logic [REG_W-1:0]           rdata1,
    input  logic                       re2,
    input  logic [$clog2(REG_NUM)-1:0] raddr2,
    output logic [REG_W-1:0]           rdata2,
    output logic                       ready_o,
    output logic                       stallreq_o
);

    localparam int unsigned AW   = $clog2(REG_NUM);
    localparam int unsigned LAST = REG_NUM - 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_next;
    logic            ready_next;
    logic [REG_W-1:0] regs [REG_NUM];

    // Sequencer state, clear counter and ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            ready_o <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ready_o <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready_next = ready_o;
        case (state)
            CLEAR: begin
                if (cnt == AW'(LAST)) begin
                    cnt_next   = '0;
                    state_next = RUN;
                    ready_next = 1'b1;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
                ready_next = 1'b0;
            end
        endcase
    end

    // Array update: clearing owns the write port until the sequencer reaches RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[cnt] <= '0;
            end else if (we && (waddr != '0)) begin
                regs[waddr] <= wdata;
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rst || !ready_o || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst || !ready_o || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

    assign stallreq_o = !ready_o;

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage MIPS pipeline: 32 × 32-bit registers with two combinational read ports serving the ID stage and one synchronous write port driven by the WB stage. `$0` is hardwired to zero. A same-cycle WB→ID bypass is built in. After every reset, an init sequencer clears all registers one per cycle and holds a stall request until the array is valid.

## Interface
Parameters:
- `REG_NUM`, 32: number of registers; the address is `log2(REG_NUM)` = 5 bits (`RegAddrBus`).
- `REG_W`, 32: register width (`RegBus`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, **synchronous, active-high** (`RstEnable` = 1'b1).
- `we`  in  1  write enable from WB (`WriteEnable` = 1).
- `waddr`  in  5  write address.
- `wdata`  in  32  write data.
- `re1`  in  1  read-port-1 enable from ID (`ReadEnable` = 1).
- `raddr1`  in  5  read-port-1 address.
- `rdata1`  out  32  read-port-1 data; combinational.
- `re2`  in  1  read-port-2 enable.
- `raddr2`  in  5  read-port-2 address.
- `rdata2`  out  32  read-port-2 data; combinational.
- `ready_o`  out  1  registered; 1 when the register array is fully initialised.
- `stallreq_o`  out  1  combinational, equal to `!ready_o`; goes to pipeline control.

## Operation
- State machine: `CLEAR` and `RUN`. It is paired with a 5-bit clear counter `cnt`.
- Reset: on any edge where `rst` = 1, set state ← `CLEAR`, `cnt` ← 0, `ready_o` ← 0. Register contents are left untouched on that edge.
- `CLEAR` (with `rst` = 0), on each edge:
  - `reg[cnt]` ← 0, then `cnt` ← `cnt` + 1.
  - When `cnt` = 31, also set state ← `RUN` and `ready_o` ← 1. The counter wraps to 0.
- In `CLEAR`, `we` is ignored and no external write occurs.
- `RUN`: on each edge, if `we` = 1 and `waddr` ≠ 0, then `reg[waddr]` ← `wdata`. A write to address 0 is discarded.
- Read port n (1 and 2 are identical and independent), first matching rule wins:
  1. `rst` = 1 → 0.
  2. `ready_o` = 0 → 0.
  3. `ren` = 0 → 0.
  4. `raddrn` = 0 → 0.
  5. `we` = 1 and `waddr` = `raddrn` → `wdata` (bypass).
  6. Otherwise → `reg[raddrn]`.
- Both ports may read the same address in the same cycle; both return identical data.
- Reset mid-`CLEAR` restarts clearing from `cnt` = 0.
- Reset in `RUN` re-enters `CLEAR`; all contents are zeroed again.

## Timing
- Write latency: data written at edge N is visible from `reg` after edge N. In cycle N itself it is visible via the bypass.
- Read latency: 0 cycles (combinational from address, enable and write inputs).
- Init: with `rst` high through edge R and low afterwards:
  - edges R+1 … R+32 clear `reg[0]` … `reg[31]`.
  - `ready_o` rises after edge R+32.
  - `stallreq_o` is 1 from edge R through edge R+32, i.e. 33 edges including the reset edge.
- Reset values: `ready_o` = 0, `stallreq_o` = 1, `rdata1` = `rdata2` = 0 (combinationally while `rst` = 1).
- There is no write/write hazard: there is a single write port.

## Test plan
- **Init sequence:** hold `rst` = 1 for 2 cycles, then 0.
  - `stallreq_o` = 1 and `ready_o` = 0 for exactly the 32 cycles after release.
  - `ready_o` = 1 after the 32nd edge.
  - Reading all 32 addresses then returns 0.
- **Write/read:** in `RUN`, write `0x1234_5678` to `$5` with `we` = 1. Next cycle, with `re1` = 1 and `raddr1` = 5: `rdata1` = `0x1234_5678`. With `re1` = 0: `rdata1` = 0.
- **Bypass:** in the same cycle, `we` = 1, `waddr` = 7, `wdata` = `0xDEAD_BEEF`, `re2` = 1, `raddr2` = 7, while `reg[7]` = `0x11`: `rdata2` = `0xDEAD_BEEF` in that cycle, and it stays `0xDEAD_BEEF` afterwards.
- **`$0` hardwire:** write `0xFFFF_FFFF` to address 0, including a same-cycle read of address 0 on both ports. Both ports return 0 in that cycle and after.
- **Writes ignored in `CLEAR`:** assert `we` = 1, `waddr` = 3, `wdata` = `0xAA` during `CLEAR`. After `ready_o` = 1, `reg[3]` reads 0.
- **Reset mid-operation:**
  - Fill `$1`–`$31` with their own index, then pulse `rst` for 1 cycle. `ready_o` drops at that edge, rises 32 edges later, and all registers read 0.
  - Pulse `rst` again at `cnt` = 10 during `CLEAR`. The counter restarts, and `ready_o` rises 32 edges after that second release.
